regfile_param: RTL

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 134 +++++++++++++
 1 files changed

// File: rtl/regfile_param.sv
// Multi-ported register file with byte-lane writes, optional write-to-read
// forwarding and a per-register pending scoreboard with a registered population count.
module regfile_param #(
   parameter  int WIDTH   = 32,
   parameter  int DEPTH   = 32,
   parameter  bit BYPASS  = 1'b1,
   parameter  bit ZERO_R0 = 1'b1,
   localparam int AW      = $clog2(DEPTH),
   localparam int NB      = WIDTH / 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    ra0,
   input  logic [AW-1:0]    ra1,
   output logic [WIDTH-1:0] rd0,
   output logic [WIDTH-1:0] rd1,
   input  logic             we0,
   input  logic [AW-1:0]    wa0,
   input  logic [WIDTH-1:0] wd0,
   input  logic [NB-1:0]    wbe0,
   input  logic             we1,
   input  logic [AW-1:0]    wa1,
   input  logic [WIDTH-1:0] wd1,
   input  logic [NB-1:0]    wbe1,
   input  logic             iss_v,
   input  logic [AW-1:0]    iss_a,
   output logic             busy0,
   output logic             busy1,
   output logic [AW:0]      pend_cnt
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   // An address is usable when it is inside the array and not the hardwired zero register.
   function automatic logic f_valid(input logic [AW-1:0] a);
      return ({1'b0, a} < DEPTH_W) && !(ZERO_R0 && (a == '0));
   endfunction

   function automatic logic [WIDTH-1:0] f_mask(input logic [NB-1:0] be);
      logic [WIDTH-1:0] m;
      m = '0;
      for (int b = 0; b < NB; b++) m[8*b +: 8] = {8{be[b]}};
      return m;
   endfunction

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] r_pend;
   logic [AW:0]      r_cnt;

   logic             w_eff0, w_eff1, w_iss;
   logic [WIDTH-1:0] w_m0, w_m1;
   logic [DEPTH-1:0] w_sel0, w_sel1, w_set, w_pend_next;
   logic [AW:0]      w_cnt_next;

   // Gating with reset keeps writes, issues and forwarding dead while reset is held.
   assign w_eff0 = reset && we0 && (|wbe0) && f_valid(wa0);
   assign w_eff1 = reset && we1 && (|wbe1) && f_valid(wa1);
   assign w_iss  = reset && iss_v && f_valid(iss_a);

   assign w_m0   = f_mask(wbe0);
   assign w_m1   = f_mask(wbe1);
   assign w_sel0 = w_eff0 ? (DEPTH'(1) << wa0)   : '0;
   assign w_sel1 = w_eff1 ? (DEPTH'(1) << wa1)   : '0;
   assign w_set  = w_iss  ? (DEPTH'(1) << iss_a) : '0;

   assign w_pend_next = (r_pend & ~(w_sel0 | w_sel1)) | w_set;

   always_comb begin
      w_cnt_next = '0;
      for (int i = 0; i < DEPTH; i++) w_cnt_next = w_cnt_next + (AW+1)'(w_pend_next[i]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend <= '0;
         r_cnt  <= '0;
      end else begin
         r_pend <= w_pend_next;
         r_cnt  <= w_cnt_next;
      end
   end

   assign pend_cnt = r_cnt;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_reg
         logic [WIDTH-1:0] w_lm0, w_lm1;
         assign w_lm0 = w_sel0[gi] ? w_m0 : '0;
         assign w_lm1 = w_sel1[gi] ? w_m1 : '0;

         // Port 1 lanes are applied last so they win on a same-address collision.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               r_mem[gi] <= '0;
            else if (w_sel0[gi] || w_sel1[gi])
               r_mem[gi] <= (((r_mem[gi] & ~w_lm0) | (wd0 & w_lm0)) & ~w_lm1) | (wd1 & w_lm1);
         end
      end
   endgenerate

   logic [AW-1:0]    w_ra   [2];
   logic [WIDTH-1:0] w_rd   [2];
   logic             w_busy [2];

   assign w_ra[0] = ra0;
   assign w_ra[1] = ra1;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic             w_hit0, w_hit1, w_full, w_pbit;
         logic [WIDTH-1:0] w_base, w_bm0, w_bm1;

         assign w_hit0 = BYPASS && w_eff0 && (wa0 == w_ra[gi]);
         assign w_hit1 = BYPASS && w_eff1 && (wa1 == w_ra[gi]);
         assign w_base = f_valid(w_ra[gi]) ? r_mem[w_ra[gi]] : '0;
         assign w_bm0  = w_hit0 ? w_m0 : '0;
         assign w_bm1  = w_hit1 ? w_m1 : '0;

         assign w_rd[gi] = (((w_base & ~w_bm0) | (wd0 & w_bm0)) & ~w_bm1) | (wd1 & w_bm1);

         // A full-word forwarded write satisfies the reader, so it is not busy this cycle.
         assign w_pbit     = f_valid(w_ra[gi]) ? r_pend[w_ra[gi]] : 1'b0;
         assign w_full     = (w_hit0 && (&wbe0)) || (w_hit1 && (&wbe1));
         assign w_busy[gi] = w_pbit && !w_full;
      end
   endgenerate

   assign rd0   = w_rd[0];
   assign rd1   = w_rd[1];
   assign busy0 = w_busy[0];
   assign busy1 = w_busy[1];

endmodule
